// File: rtl/four_bit_adder.sv
// Registered ripple-carry adder: a chain of single-bit full-adder cells feeding
// an output register that captures {carry, sum} on every rising edge.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module four_bit_adder #(
  parameter int unsigned bits = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] A,
  input  logic [bits-1:0] B,
  input  logic            CarryIN,
  output logic [bits-1:0] Sum,
  output logic            CarryOUT
);

  // carry[i] enters cell i; carry[bits] leaves the MSB cell.
  logic [bits:0]   carry;
  logic [bits-1:0] sum_comb;

  assign carry[0] = CarryIN;

  for (genvar i = 0; i < bits; i++) begin : g_cell
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (sum_comb[i]),
      .cout (carry[i+1])
    );
  end

  // NOTE: registered outputs use non-blocking assignments so every flop samples
  // the pre-edge values; reset is checked first so it wins over the capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum      <= '0;
      CarryOUT <= 1'b0;
    end else begin
      Sum      <= sum_comb;
      CarryOUT <= carry[bits];
    end
  end

endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder: directed corners, exhaustive sweep
// with a mid-stream reset, and random vectors against an arithmetic model.

module tb_four_bit_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       ci_in;
  logic [3:0] sum_out;
  logic       co_out;

  int total = 0;
  int bad   = 0;

  four_bit_adder #(.bits(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a_in),
    .B        (b_in),
    .CarryIN  (ci_in),
    .Sum      (sum_out),
    .CarryOUT (co_out)
  );

  always #5 clk = ~clk;

  // Reference: plain 5-bit arithmetic, forced to zero while reset is sampled.
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic ci, input logic r);
    if (r) return 5'd0;
    return 5'(a) + 5'(b) + 5'(ci);
  endfunction

  // Drive inputs away from the edge, then let one rising edge capture them and
  // settle so the outputs can be sampled #1 later.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic r);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    ci_in = ci;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [4:0] exp;
    for (int k = 0; k < 2; k++) begin
      apply(4'hF, 4'hF, 1'b1, 1'b1);
      exp = 5'd0;
      total++;
      if ({co_out, sum_out} !== exp) begin
        bad++;
        $display("FAIL reset_edge%0d got=%b_%h want=%b_%h", k, co_out, sum_out, exp[4], exp[3:0]);
      end
    end
    apply(4'hF, 4'hF, 1'b1, 1'b0);
    exp = model(4'hF, 4'hF, 1'b1, 1'b0);
    total++;
    if ({co_out, sum_out} !== exp) begin
      bad++;
      $display("FAIL reset_release got=%b_%h want=%b_%h", co_out, sum_out, exp[4], exp[3:0]);
    end
  endtask

  task automatic test_directed;
    logic [3:0] av [6] = '{4'd4, 4'd4, 4'd15, 4'd8, 4'hF, 4'd0};
    logic [3:0] bv [6] = '{4'd5, 4'd5, 4'd1,  4'd8, 4'h0, 4'd0};
    logic       cv [6] = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0};
    logic [4:0] want [6] = '{5'd9, 5'd10, 5'd16, 5'd16, 5'd16, 5'd0};
    for (int k = 0; k < 6; k++) begin
      apply(av[k], bv[k], cv[k], 1'b0);
      total++;
      if ({co_out, sum_out} !== want[k]) begin
        bad++;
        $display("FAIL directed%0d a=%h b=%h ci=%b got=%b_%h want=%b_%h",
                 k, av[k], bv[k], cv[k], co_out, sum_out, want[k][4], want[k][3:0]);
      end
    end
  endtask

  // One vector per clock over all 512 input combinations; one edge in the
  // middle is a reset, and the vector after it must compute normally.
  task automatic test_exhaustive;
    logic [4:0] exp;
    logic       r;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    int         reset_at;
    reset_at = 100 + int'($urandom_range(0, 200));
    for (int n = 0; n < 512; n++) begin
      ci = 1'(n >> 8);
      a  = 4'(n >> 4);
      b  = 4'(n);
      r  = (n == reset_at);
      apply(a, b, ci, r);
      exp = model(a, b, ci, r);
      total++;
      if ({co_out, sum_out} !== exp) begin
        bad++;
        $display("FAIL sweep n=%0d rst=%b a=%h b=%h ci=%b got=%b_%h want=%b_%h",
                 n, r, a, b, ci, co_out, sum_out, exp[4], exp[3:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    for (int n = 0; n < 200; n++) begin
      a  = 4'($urandom);
      b  = 4'($urandom);
      ci = 1'($urandom);
      apply(a, b, ci, 1'b0);
      exp = model(a, b, ci, 1'b0);
      total++;
      if ({co_out, sum_out} !== exp) begin
        bad++;
        $display("FAIL random n=%0d a=%h b=%h ci=%b got=%b_%h want=%b_%h",
                 n, a, b, ci, co_out, sum_out, exp[4], exp[3:0]);
      end
    end
  endtask

  task automatic test_hold;
    logic [4:0] exp;
    apply(4'd7, 4'd6, 1'b1, 1'b0);
    exp = model(4'd7, 4'd6, 1'b1, 1'b0);
    // Inputs change between edges; outputs must not move until the next edge.
    #2;
    a_in  = 4'd0;
    b_in  = 4'd0;
    ci_in = 1'b0;
    #1;
    total++;
    if ({co_out, sum_out} !== exp) begin
      bad++;
      $display("FAIL hold got=%b_%h want=%b_%h", co_out, sum_out, exp[4], exp[3:0]);
    end
  endtask

  initial begin
    rst   = 1'b1;
    a_in  = '0;
    b_in  = '0;
    ci_in = 1'b0;
    test_reset();
    test_directed();
    test_exhaustive();
    test_back_to_back();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
